// File: rtl/biquad_sequencer_if.sv
// Frame, coefficient-bank and status signals of the time-multiplexed biquad sequencer.
// master = sample source / coefficient bank side, slave = sequencer.
interface biquad_sequencer_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ACC_W    = 64
);
   logic                         sample_stb;
   logic [CHANNELS*DATA_W-1:0]   sample_in;
   logic [2:0]                   filter;
   logic [2:0]                   coef_bank;
   logic [2:0]                   coef_idx;
   logic [ACC_W-1:0]             coef_data;
   logic [CHANNELS*DATA_W-1:0]   sample_out;
   logic                         out_valid;
   logic                         busy;
   logic                         overrun;

   modport master (
      output sample_stb, sample_in, filter, coef_data,
      input  coef_bank, coef_idx, sample_out, out_valid, busy, overrun
   );

   modport slave (
      input  sample_stb, sample_in, filter, coef_data,
      output coef_bank, coef_idx, sample_out, out_valid, busy, overrun
   );
endinterface

// File: rtl/biquad_sequencer.sv
// Shares one signed MAC across CHANNELS biquads, five terms per channel per sample strobe.
// Optional FLUSH_ON_SWITCH_EN: clear all channel histories when a frame selects a new bank.
module biquad_sequencer #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ACC_W    = 64,
   parameter int unsigned SHIFT    = 30
) (
   input  logic                clk_144,
   input  logic                reset,
   biquad_sequencer_if.slave   bus
);
   localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned PROD_W = ACC_W + DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

   state_t                   state;
   logic [CH_W-1:0]          ch;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] x0 [CHANNELS];
   logic signed [DATA_W-1:0] x1 [CHANNELS];
   logic signed [DATA_W-1:0] x2 [CHANNELS];
   logic signed [DATA_W-1:0] y1 [CHANNELS];
   logic signed [DATA_W-1:0] y2 [CHANNELS];

   logic signed [DATA_W-1:0] op_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  term_c;
   logic signed [ACC_W-1:0]  sum_c;
   logic signed [DATA_W-1:0] sat_c;

   // Operand select, full-precision product, shift, accumulate and output clamp
   always_comb begin
      op_c = '0;
      case (bus.coef_idx)
         3'd0:    op_c = x0[ch];
         3'd1:    op_c = x1[ch];
         3'd2:    op_c = x2[ch];
         3'd3:    op_c = y1[ch];
         3'd4:    op_c = y2[ch];
         default: op_c = '0;
      endcase
      prod_c = PROD_W'($signed(bus.coef_data)) * PROD_W'(op_c);
      term_c = ACC_W'(prod_c >>> SHIFT);
      sum_c  = acc + term_c;
      if (acc > SAT_MAX)      sat_c = DATA_W'(SAT_MAX);
      else if (acc < SAT_MIN) sat_c = DATA_W'(SAT_MIN);
      else                    sat_c = DATA_W'(acc);
   end

   always_ff @(posedge clk_144) begin
      if (reset) begin
         state          <= IDLE;
         ch             <= '0;
         acc            <= '0;
         bus.coef_bank  <= '0;
         bus.coef_idx   <= '0;
         bus.sample_out <= '0;
         bus.out_valid  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.overrun    <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            x0[c] <= '0;
            x1[c] <= '0;
            x2[c] <= '0;
            y1[c] <= '0;
            y2[c] <= '0;
         end
      end else begin
         bus.out_valid <= 1'b0;
         if (bus.sample_stb && (state != IDLE)) bus.overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.sample_stb) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     x0[c] <= bus.sample_in[c*DATA_W +: DATA_W];
`ifdef FLUSH_ON_SWITCH_EN
                     if (bus.filter != bus.coef_bank) begin
                        x1[c] <= '0;
                        x2[c] <= '0;
                        y1[c] <= '0;
                        y2[c] <= '0;
                     end
`endif
                  end
                  bus.coef_bank <= bus.filter;
                  bus.coef_idx  <= '0;
                  bus.busy      <= 1'b1;
                  acc           <= '0;
                  ch            <= '0;
                  state         <= MAC;
               end
            end
            MAC: begin
               acc <= sum_c;
               if (bus.coef_idx == 3'd4) state <= WB;
               else bus.coef_idx <= bus.coef_idx + 3'd1;
            end
            WB: begin
               // y history keeps the clamped value so clipping cannot wind up the recursion
               x2[ch] <= x1[ch];
               x1[ch] <= x0[ch];
               y2[ch] <= y1[ch];
               y1[ch] <= sat_c;
               bus.sample_out[ch*DATA_W +: DATA_W] <= sat_c;
               acc          <= '0;
               bus.coef_idx <= '0;
               if (ch == CH_W'(CHANNELS - 1)) begin
                  state <= DONE;
               end else begin
                  ch    <= ch + CH_W'(1);
                  state <= MAC;
               end
            end
            DONE: begin
               bus.out_valid <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_biquad_sequencer.sv
// Bench for biquad_sequencer (CHANNELS=2): directed frame table, multi-cycle corner
// sequences, and random frames against a difference-equation reference model.
module tb_biquad_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   biquad_sequencer_if #(.CHANNELS(2), .DATA_W(16), .ACC_W(64)) bus ();

   biquad_sequencer #(.CHANNELS(2), .DATA_W(16), .ACC_W(64), .SHIFT(30)) dut (
      .clk_144 (clk),
      .reset   (reset),
      .bus     (bus)
   );

   logic signed [63:0] coef_mem [8][8];
   assign bus.coef_data = coef_mem[bus.coef_bank][bus.coef_idx];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Reference model: per-channel histories of the direct-form I biquad
   longint mx1 [2], mx2 [2], my1 [2], my2 [2];
   logic [2:0] mbank;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
      end
      mbank = 3'd0;
   endtask

   task automatic model_frame(input logic [2:0] f, input longint a, input longint b,
                              output longint e0, output longint e1);
      longint xin, y, res [2];
`ifdef FLUSH_ON_SWITCH_EN
      if (f != mbank) begin
         for (int c = 0; c < 2; c++) begin
            mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
         end
      end
`endif
      for (int c = 0; c < 2; c++) begin
         xin = (c == 0) ? a : b;
         y = ((longint'(coef_mem[f][0]) * xin) >>> 30)
           + ((longint'(coef_mem[f][1]) * mx1[c]) >>> 30)
           + ((longint'(coef_mem[f][2]) * mx2[c]) >>> 30)
           + ((longint'(coef_mem[f][3]) * my1[c]) >>> 30)
           + ((longint'(coef_mem[f][4]) * my2[c]) >>> 30);
         if (y > 32767) y = 32767;
         if (y < -32768) y = -32768;
         mx2[c] = mx1[c]; mx1[c] = xin;
         my2[c] = my1[c]; my1[c] = y;
         res[c] = y;
      end
      mbank = f;
      e0 = res[0];
      e1 = res[1];
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.sample_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One frame: strobe sampled at edge 0, wait (bounded) for out_valid
   task automatic run_frame(input logic [2:0] f, input logic signed [15:0] a,
                            input logic signed [15:0] b, output int lat,
                            output logic signed [15:0] o0, output logic signed [15:0] o1);
      @(negedge clk);
      bus.filter     = f;
      bus.sample_in  = {b, a};
      bus.sample_stb = 1'b1;
      @(posedge clk);
      #1 bus.sample_stb = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = k;
            break;
         end
      end
      o0 = bus.sample_out[15:0];
      o1 = bus.sample_out[31:16];
   endtask

   typedef struct {
      bit         rst;
      logic [2:0] f;
      int         a, b, e0, e1;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int lat, pulses, first;
      logic signed [15:0] o0, o1;
      logic [13:0] busy_obs;
      logic bank_ok, rst_ok;
      longint e0, e1;
      logic signed [15:0] ra, rb;
      logic [2:0] rf;

      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) coef_mem[i][j] = 64'sd0;
      coef_mem[0][0] = 64'sd1 <<< 30;
      coef_mem[1][0] = 64'sd1 <<< 31;
      coef_mem[2][1] = 64'sd1 <<< 30;
      coef_mem[3][3] = 64'sd1 <<< 29;
      coef_mem[4][0] = 64'sd1 <<< 30;
      coef_mem[4][3] = 64'sd1 <<< 29;

      tbl[0]  = '{1'b1, 3'd0,   1000,  -1000,   1000,  -1000};
      tbl[1]  = '{1'b1, 3'd1,  20000, -20000,  32767, -32768};
      tbl[2]  = '{1'b1, 3'd2,    500,   -300,      0,      0};
      tbl[3]  = '{1'b0, 3'd2,      0,      0,    500,   -300};
      tbl[4]  = '{1'b1, 3'd3,   1000,   1000,      0,      0};
      tbl[5]  = '{1'b0, 3'd3,      0,      0,      0,      0};
      tbl[6]  = '{1'b0, 3'd3,      0,      0,      0,      0};
      tbl[7]  = '{1'b1, 3'd4,   1000,  -1000,   1000,  -1000};
      tbl[8]  = '{1'b0, 3'd4,      0,      0,    500,   -500};
      tbl[9]  = '{1'b0, 3'd4,      0,      0,    250,   -250};
      tbl[10] = '{1'b1, 3'd1,  16383, -16384,  32766, -32768};
      tbl[11] = '{1'b0, 3'd1,  16384, -16385,  32767, -32768};
      tbl[12] = '{1'b1, 3'd0, -32768,  32767, -32768,  32767};

      reset = 1'b1;
      bus.sample_stb = 1'b0;
      bus.sample_in  = '0;
      bus.filter     = 3'd0;
      do_reset();
      #1;
      chk("rst_sample_out", longint'(bus.sample_out), 0);
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_overrun", longint'(bus.overrun), 0);
      chk("rst_coef_bank", longint'(bus.coef_bank), 0);
      chk("rst_coef_idx", longint'(bus.coef_idx), 0);

      // Directed frame table
      for (int i = 0; i < 13; i++) begin
         if (tbl[i].rst) do_reset();
         run_frame(tbl[i].f, 16'(tbl[i].a), 16'(tbl[i].b), lat, o0, o1);
         chk($sformatf("tbl%0d_latency", i), lat, 13);
         chk($sformatf("tbl%0d_ch0", i), o0, tbl[i].e0);
         chk($sformatf("tbl%0d_ch1", i), o1, tbl[i].e1);
      end

      // Busy window and mid-frame filter change
      do_reset();
      @(negedge clk);
      bus.filter = 3'd0; bus.sample_in = {16'sd77, -16'sd55}; bus.sample_stb = 1'b1;
      @(posedge clk);
      #1 bus.sample_stb = 1'b0;
      busy_obs = '0;
      busy_obs[0] = bus.busy;
      bank_ok = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         if (k == 2) bus.filter = 3'd3;
         @(posedge clk);
         #1 busy_obs[k] = bus.busy;
         if (k <= 12 && bus.coef_bank != 3'd0) bank_ok = 1'b0;
      end
      chk("busy_window", longint'(busy_obs), 64'h1FFF);
      chk("out_valid_at_13", longint'(bus.out_valid), 1);
      chk("bank_held", longint'(bank_ok), 1);
      chk("filter_change_ch0", longint'($signed(bus.sample_out[15:0])), -55);
      chk("filter_change_ch1", longint'($signed(bus.sample_out[31:16])), 77);
      bus.filter = 3'd0;

      // Overrun: second strobe at edge 5 is ignored, sticky flag until reset
      do_reset();
      @(negedge clk);
      bus.sample_in = {-16'sd1000, 16'sd1000}; bus.sample_stb = 1'b1;
      @(posedge clk);
      #1 bus.sample_stb = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.sample_in = {16'sd9, 16'sd9}; bus.sample_stb = 1'b1;
      @(posedge clk);
      #1 bus.sample_stb = 1'b0;
      chk("overrun_set", longint'(bus.overrun), 1);
      pulses = 0; first = -1;
      for (int k = 6; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      chk("overrun_pulses", pulses, 1);
      chk("overrun_first_valid", first, 13);
      chk("overrun_ch0", longint'($signed(bus.sample_out[15:0])), 1000);
      run_frame(3'd0, 16'sd5, -16'sd6, lat, o0, o1);
      chk("overrun_next_ch0", o0, 5);
      chk("overrun_sticky", longint'(bus.overrun), 1);
      do_reset();
      #1 chk("overrun_cleared", longint'(bus.overrun), 0);

      // Reset sampled at edge 7 aborts the frame
      @(negedge clk);
      bus.filter = 3'd0; bus.sample_in = {16'sd321, 16'sd123}; bus.sample_stb = 1'b1;
      @(posedge clk);
      #1 bus.sample_stb = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(posedge clk);
         #1 if (bus.out_valid) pulses++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      rst_ok = (bus.sample_out == '0) && !bus.out_valid && !bus.busy && !bus.overrun
               && (bus.coef_bank == 3'd0) && (bus.coef_idx == 3'd0);
      chk("midframe_reset_outputs", longint'(rst_ok), 1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (20) begin
         @(posedge clk);
         #1 if (bus.out_valid) pulses++;
      end
      chk("midframe_no_valid", pulses, 0);
      run_frame(3'd0, 16'sd1234, -16'sd4321, lat, o0, o1);
      chk("after_reset_latency", lat, 13);
      chk("after_reset_ch0", o0, 1234);
      chk("after_reset_ch1", o1, -4321);

      // History across a bank switch
      do_reset();
      run_frame(3'd1, 16'sd300, -16'sd400, lat, o0, o1);
      chk("prime_ch0", o0, 600);
      run_frame(3'd2, 16'sd0, 16'sd0, lat, o0, o1);
`ifdef FLUSH_ON_SWITCH_EN
      chk("switch_ch0", o0, 0);
      chk("switch_ch1", o1, 0);
`else
      chk("switch_ch0", o0, 300);
      chk("switch_ch1", o1, -400);
`endif

      // Random coefficients and samples on banks 5 and 6 against the model
      for (int b = 5; b <= 6; b++)
         for (int k = 0; k < 5; k++)
            coef_mem[b][k] = longint'($urandom_range(0, 32'h7FFF_FFFF)) - 64'sd1073741824;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         rf = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'd5;
         ra = 16'($urandom);
         rb = 16'($urandom);
         model_frame(rf, ra, rb, e0, e1);
         run_frame(rf, ra, rb, lat, o0, o1);
         chk($sformatf("rand%0d_latency", i), lat, 13);
         chk($sformatf("rand%0d_ch0", i), o0, e0);
         chk($sformatf("rand%0d_ch1", i), o1, e1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
